// File: rtl/ms_timebase_timer.sv
// Millisecond timebase: clock prescaler, decade tick cascade (10 ms / 100 ms / 1 s)
// and a one-shot/periodic countdown timer clocked by the 1 ms strobe.
module ms_timebase_timer #(
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [PERIOD_W-1:0] period_ms,
  output logic                tick_1ms,
  output logic                tick_10ms,
  output logic                tick_100ms,
  output logic                tick_1s,
  output logic                busy,
  output logic                time_out,
  output logic [PERIOD_W-1:0] remaining_ms
);

  localparam int unsigned PRE_W = $clog2(CLKS_PER_MS);
  localparam int unsigned DEC_W = 4;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(9);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [PRE_W-1:0]    pre_cnt;
  logic [DEC_W-1:0]    c10;
  logic [DEC_W-1:0]    c100;
  logic [DEC_W-1:0]    c1000;
  logic [PERIOD_W-1:0] period_q;
  logic                mode_q;
  state_t              state;

  logic ms_strobe_c;
  logic c10_wrap_c;
  logic c100_wrap_c;
  logic c1000_wrap_c;
  logic start_ok_c;

  assign ms_strobe_c  = enable && (pre_cnt == PRE_MAX);
  assign c10_wrap_c   = ms_strobe_c && (c10 == DEC_MAX);
  assign c100_wrap_c  = c10_wrap_c && (c100 == DEC_MAX);
  assign c1000_wrap_c = c100_wrap_c && (c1000 == DEC_MAX);
  assign start_ok_c   = start && (period_ms != '0);

  // Free-running prescaler; never reset by start so tick phase stays undisturbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= ms_strobe_c ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Decade cascade: each stage advances only when every lower stage wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c10   <= '0;
      c100  <= '0;
      c1000 <= '0;
    end else begin
      if (ms_strobe_c) begin
        c10 <= c10_wrap_c ? '0 : c10 + DEC_W'(1);
      end
      if (c10_wrap_c) begin
        c100 <= c100_wrap_c ? '0 : c100 + DEC_W'(1);
      end
      if (c100_wrap_c) begin
        c1000 <= c1000_wrap_c ? '0 : c1000 + DEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_1ms   <= 1'b0;
      tick_10ms  <= 1'b0;
      tick_100ms <= 1'b0;
      tick_1s    <= 1'b0;
    end else begin
      tick_1ms   <= ms_strobe_c;
      tick_10ms  <= c10_wrap_c;
      tick_100ms <= c100_wrap_c;
      tick_1s    <= c1000_wrap_c;
    end
  end

  // Countdown FSM; priority stop > start > ms strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      time_out     <= 1'b0;
      remaining_ms <= '0;
      period_q     <= '0;
      mode_q       <= 1'b0;
    end else begin
      time_out <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        busy         <= 1'b0;
        remaining_ms <= '0;
      end else if (start_ok_c) begin
        state        <= RUN;
        busy         <= 1'b1;
        period_q     <= period_ms;
        mode_q       <= mode;
        remaining_ms <= period_ms;
      end else if (ms_strobe_c && (state == RUN)) begin
        if (remaining_ms > PERIOD_W'(1)) begin
          remaining_ms <= remaining_ms - PERIOD_W'(1);
        end else begin
          time_out <= 1'b1;
          if (mode_q) begin
            remaining_ms <= period_q;
          end else begin
            state        <= IDLE;
            busy         <= 1'b0;
            remaining_ms <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ms_timebase_timer.sv
// Self-checking bench for ms_timebase_timer: cycle model feeds a scoreboard queue,
// plus directed timing checks per scenario.
module tb_ms_timebase_timer;

  localparam int unsigned CPM = 4;
  localparam int unsigned PW  = 16;
  localparam int unsigned VW  = PW + 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] period_ms = '0;
  logic          tick_1ms, tick_10ms, tick_100ms, tick_1s;
  logic          busy, time_out;
  logic [PW-1:0] remaining_ms;

  always #5 clk = ~clk;

  ms_timebase_timer #(.CLKS_PER_MS(CPM), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .period_ms(period_ms), .tick_1ms(tick_1ms),
    .tick_10ms(tick_10ms), .tick_100ms(tick_100ms), .tick_1s(tick_1s),
    .busy(busy), .time_out(time_out), .remaining_ms(remaining_ms)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] exp_v;

  // Reference model state: time is tracked as enabled cycles and elapsed ms.
  int m_en_cnt, m_ms, m_rem, m_period;
  bit m_run, m_mode;

  function automatic logic [VW-1:0] obs();
    return {tick_1ms, tick_10ms, tick_100ms, tick_1s, busy, time_out, remaining_ms};
  endfunction

  task automatic model_reset();
    m_en_cnt = 0; m_ms = 0; m_rem = 0; m_period = 0;
    m_run = 0; m_mode = 0;
    sb.delete();
  endtask

  task automatic model_step();
    bit strobe, t1, t10, t100, t1s, to;
    strobe = enable && ((m_en_cnt % CPM) == CPM - 1);
    if (enable) m_en_cnt++;
    if (strobe) m_ms++;
    t1   = strobe;
    t10  = strobe && (m_ms % 10 == 0);
    t100 = strobe && (m_ms % 100 == 0);
    t1s  = strobe && (m_ms % 1000 == 0);
    to   = 0;
    if (stop) begin
      m_run = 0; m_rem = 0;
    end else if (start && period_ms != 0) begin
      m_run = 1; m_mode = mode; m_period = int'(period_ms); m_rem = int'(period_ms);
    end else if (strobe && m_run) begin
      if (m_rem > 1) m_rem--;
      else begin
        to = 1;
        if (m_mode) m_rem = m_period;
        else begin m_run = 0; m_rem = 0; end
      end
    end
    sb.push_back({t1, t10, t100, t1s, m_run, to, PW'(m_rem)});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs() !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", obs()); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_ticks();
    int f10, f100, f1s;
    bit all4;
    f10 = 0; f100 = 0; f1s = 0; all4 = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL sb_ticks cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (cyc <= 12) begin
        n_cmp++;
        if (tick_1ms !== (cyc % 4 == 0)) begin n_err++; $display("FAIL tick_1ms_pos cyc=%0d got=%b", cyc, tick_1ms); end
      end
      if (tick_10ms && f10 == 0) f10 = cyc;
      if (tick_100ms && f100 == 0) f100 = cyc;
      if (tick_1s && f1s == 0) begin
        f1s = cyc;
        all4 = tick_1ms && tick_10ms && tick_100ms;
      end
    end
    n_cmp++; if (f10 !== 40) begin n_err++; $display("FAIL first_10ms got=%0d exp=40", f10); end
    n_cmp++; if (f100 !== 400) begin n_err++; $display("FAIL first_100ms got=%0d exp=400", f100); end
    n_cmp++; if (f1s !== 4000) begin n_err++; $display("FAIL first_1s got=%0d exp=4000", f1s); end
    n_cmp++; if (all4 !== 1'b1) begin n_err++; $display("FAIL coincident_ticks got=%b exp=1", all4); end
  endtask

  task automatic test_one_shot();
    int nt, n_to;
    bit seen;
    nt = 0; n_to = 0; seen = 0;
    mode = 1'b0; period_ms = PW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_oneshot_start got=%h exp=%h", obs(), exp_v); end
    n_cmp++; if (remaining_ms !== PW'(3) || busy !== 1'b1) begin n_err++; $display("FAIL oneshot_load rem=%0d busy=%b exp 3/1", remaining_ms, busy); end
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_oneshot cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (tick_1ms) begin
        nt++;
        n_cmp++; if (remaining_ms !== PW'(3 - nt)) begin n_err++; $display("FAIL oneshot_rem got=%0d exp=%0d", remaining_ms, 3 - nt); end
      end
      if (time_out) begin
        seen = 1;
        n_cmp++; if (nt !== 3 || tick_1ms !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL oneshot_expiry ticks=%0d t1=%b busy=%b exp 3/1/0", nt, tick_1ms, busy); end
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL oneshot_timeout got=none exp=pulse"); end
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_oneshot_after cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (time_out) n_to++;
    end
    n_cmp++; if (n_to !== 0) begin n_err++; $display("FAIL oneshot_no_repeat got=%0d exp=0", n_to); end
  endtask

  task automatic test_periodic();
    int to_cyc[$];
    int n_to;
    n_to = 0;
    mode = 1'b1; period_ms = PW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_per_start got=%h exp=%h", obs(), exp_v); end
    for (int i = 0; i < 80 && to_cyc.size() < 4; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_periodic cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (time_out) begin
        to_cyc.push_back(cyc);
        n_cmp++; if (remaining_ms !== PW'(2)) begin n_err++; $display("FAIL per_reload got=%0d exp=2", remaining_ms); end
        period_ms = PW'(5); mode = 1'b0;
      end
    end
    n_cmp++; if (to_cyc.size() !== 4) begin n_err++; $display("FAIL per_count got=%0d exp=4", to_cyc.size()); end
    for (int k = 1; k < to_cyc.size(); k++) begin
      n_cmp++; if (to_cyc[k] - to_cyc[k-1] !== 8) begin n_err++; $display("FAIL per_spacing got=%0d exp=8", to_cyc[k] - to_cyc[k-1]); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_per_stop got=%h exp=%h", obs(), exp_v); end
    n_cmp++; if (busy !== 1'b0 || remaining_ms !== '0) begin n_err++; $display("FAIL per_stop busy=%b rem=%0d exp 0/0", busy, remaining_ms); end
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_per_after cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (time_out) n_to++;
    end
    n_cmp++; if (n_to !== 0) begin n_err++; $display("FAIL per_no_timeout got=%0d exp=0", n_to); end
  endtask

  // Runs a one-shot of 5 ms started just after a tick_1ms, optionally frozen for 20 cycles.
  task automatic run_freeze(input bit pause, output int delta);
    int t0;
    bit seen;
    logic [PW-1:0] hold_rem;
    logic hold_busy;
    seen = 0; delta = -1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_frz_align cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (tick_1ms) seen = 1;
    end
    mode = 1'b0; period_ms = PW'(5); start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_frz_start got=%h exp=%h", obs(), exp_v); end
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (pause && i == 6) begin
        enable = 1'b0;
        hold_rem = remaining_ms; hold_busy = busy;
        for (int j = 0; j < 20; j++) begin
          tick();
          exp_v = sb.pop_front();
          n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_frozen cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
          n_cmp++;
          if ({tick_1ms, tick_10ms, tick_100ms, tick_1s} !== 4'b0 || remaining_ms !== hold_rem || busy !== hold_busy) begin
            n_err++; $display("FAIL frozen_hold cyc=%0d ticks=%b%b%b%b rem=%0d exp_rem=%0d busy=%b", cyc, tick_1ms, tick_10ms, tick_100ms, tick_1s, remaining_ms, hold_rem, busy);
          end
        end
        enable = 1'b1;
      end
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_frz_run cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (time_out) begin seen = 1; delta = cyc - t0; end
    end
  endtask

  task automatic test_freeze();
    int da, db;
    run_freeze(1'b0, da);
    n_cmp++; if (da !== 19) begin n_err++; $display("FAIL frz_reference got=%0d exp=19", da); end
    run_freeze(1'b1, db);
    n_cmp++; if (db !== da + 20) begin n_err++; $display("FAIL frz_delay got=%0d exp=%0d", db, da + 20); end
  endtask

  task automatic test_corners();
    int t0, delta;
    bit seen;
    mode = 1'b1; period_ms = '0; start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_zero got=%h exp=%h", obs(), exp_v); end
    n_cmp++; if (busy !== 1'b0 || remaining_ms !== '0) begin n_err++; $display("FAIL zero_period busy=%b rem=%0d exp 0/0", busy, remaining_ms); end
    mode = 1'b0; period_ms = PW'(9); start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_run9 got=%h exp=%h", obs(), exp_v); end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_run9_wait cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
    end
    period_ms = PW'(7); start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_restart got=%h exp=%h", obs(), exp_v); end
    n_cmp++; if (remaining_ms !== PW'(7) || busy !== 1'b1) begin n_err++; $display("FAIL restart rem=%0d busy=%b exp 7/1", remaining_ms, busy); end
    period_ms = PW'(4); start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_start_stop got=%h exp=%h", obs(), exp_v); end
    n_cmp++; if (busy !== 1'b0 || remaining_ms !== '0) begin n_err++; $display("FAIL start_stop busy=%b rem=%0d exp 0/0", busy, remaining_ms); end
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_strobe_align cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (tick_1ms) seen = 1;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_strobe_wait cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
    end
    mode = 1'b0; period_ms = PW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_strobe_start got=%h exp=%h", obs(), exp_v); end
    n_cmp++; if (tick_1ms !== 1'b1 || remaining_ms !== PW'(2)) begin n_err++; $display("FAIL strobe_start t1=%b rem=%0d exp 1/2", tick_1ms, remaining_ms); end
    seen = 0; delta = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_strobe_run cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (time_out) begin seen = 1; delta = cyc - t0; end
    end
    n_cmp++; if (delta !== 8) begin n_err++; $display("FAIL strobe_uncounted got=%0d exp=8", delta); end
  endtask

  task automatic test_async_reset();
    int first;
    first = 0;
    mode = 1'b1; period_ms = PW'(50); start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_ar_start got=%h exp=%h", obs(), exp_v); end
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_ar_run cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (obs() !== '0) begin n_err++; $display("FAIL async_clear got=%h exp=0", obs()); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = sb.pop_front();
      n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL sb_ar_after cyc=%0d got=%h exp=%h", cyc, obs(), exp_v); end
      if (tick_1ms && first == 0) first = cyc;
    end
    n_cmp++; if (first !== 4) begin n_err++; $display("FAIL ar_first_tick got=%0d exp=4", first); end
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_one_shot();
    test_periodic();
    test_freeze();
    test_corners();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
